alu_req_sequencer: RTL and testbench

Upstream issue/response stage wrapped around the registered 32-bit ALU. Accepts operation requests over a valid/ready handshake, drives the ALU operand and control inputs, tracks the ALU's one-cycle registered latency, and captures each result plus zero flag into a tagged response FIFO with its own valid/ready handshake. Credit-based admission guarantees no ALU result is ever dropped under consumer back-pressure.

---
 rtl/alu_req_sequencer_if.sv | 29 ++
 rtl/alu_req_sequencer.sv | 170 +++++++++++++++++
 tb/tb_alu_req_sequencer.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_req_sequencer_if.sv
// Request/response handshake bundle for alu_req_sequencer; master is the
// requester/consumer side, slave is the sequencer.
interface alu_req_sequencer_if #(
  parameter int TAG_W = 4
) ();
  logic             req_valid;
  logic             req_ready;
  logic [3:0]       req_op;
  logic [31:0]      req_a;
  logic [31:0]      req_b;
  logic [TAG_W-1:0] req_tag;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [31:0]      rsp_result;
  logic             rsp_zero;
  logic             rsp_illegal;
  logic [TAG_W-1:0] rsp_tag;

  modport master (
    output req_valid, req_op, req_a, req_b, req_tag, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_zero, rsp_illegal, rsp_tag
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, req_tag, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_zero, rsp_illegal, rsp_tag
  );
endinterface

// File: rtl/alu_req_sequencer.sv
// Issue/track stage around a registered 32-bit ALU, returning each result in a
// tagged response FIFO; credit admission keeps the FIFO from ever overflowing.
module alu_req_sequencer #(
  parameter int TAG_W     = 4,
  parameter int RES_DEPTH = 4
) (
  input  logic                clk,
  input  logic                clear,
  alu_req_sequencer_if.slave  bus,
  output logic [31:0]         alu_in0,
  output logic [31:0]         alu_in1,
  output logic [3:0]          control_signal,
  input  logic [31:0]         alu_out,
  input  logic                zero_flag
);

  localparam int PTR_W = $clog2(RES_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int SUM_W = CNT_W + 1;
  localparam logic [SUM_W-1:0] DEPTH_C = SUM_W'(RES_DEPTH);
  localparam logic [3:0] FIRST_ILLEGAL_OP = 4'd10;

  typedef struct packed {
    logic [31:0]      result;
    logic             zero;
    logic             illegal;
    logic [TAG_W-1:0] tag;
  } rsp_entry_t;

  // Issue stage S1
  logic             s1_valid_q, s1_valid_d;
  logic [3:0]       s1_op_q, s1_op_d;
  logic [31:0]      s1_a_q, s1_a_d;
  logic [31:0]      s1_b_q, s1_b_d;
  logic [TAG_W-1:0] s1_tag_q, s1_tag_d;

  // Track stage S2, aligned with the ALU output register
  logic             s2_valid_q, s2_valid_d;
  logic [TAG_W-1:0] s2_tag_q, s2_tag_d;
  logic             s2_illegal_q, s2_illegal_d;

  // Response FIFO
  rsp_entry_t       mem_q [RES_DEPTH];
  rsp_entry_t       mem_d [RES_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic             req_ready_q, req_ready_d;
  logic             rsp_valid_q, rsp_valid_d;

  logic             accept_s;
  logic             push_s;
  logic             pop_s;
  logic [SUM_W-1:0] credit_sum_s;
  rsp_entry_t       head_s;
  rsp_entry_t       push_entry_s;

  // Handshake qualifiers and S1/S2 next state
  always_comb begin
    accept_s     = bus.req_valid && req_ready_q;
    push_s       = s2_valid_q;
    pop_s        = rsp_valid_q && bus.rsp_ready;

    s1_valid_d   = accept_s;
    s1_op_d      = s1_op_q;
    s1_a_d       = s1_a_q;
    s1_b_d       = s1_b_q;
    s1_tag_d     = s1_tag_q;
    if (accept_s) begin
      s1_op_d  = bus.req_op;
      s1_a_d   = bus.req_a;
      s1_b_d   = bus.req_b;
      s1_tag_d = bus.req_tag;
    end else begin
      s1_op_d  = s1_op_q;
    end

    s2_valid_d   = s1_valid_q;
    s2_tag_d     = s1_tag_q;
    s2_illegal_d = (s1_op_q >= FIRST_ILLEGAL_OP);
  end

  // FIFO storage, pointers and occupancy next state
  always_comb begin
    push_entry_s.result  = alu_out;
    push_entry_s.zero    = zero_flag;
    push_entry_s.illegal = s2_illegal_q;
    push_entry_s.tag     = s2_tag_q;

    for (int i = 0; i < RES_DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end
    if (push_s) begin
      mem_d[wr_ptr_q] = push_entry_s;
    end else begin
      mem_d[wr_ptr_q] = mem_q[wr_ptr_q];
    end

    wr_ptr_d = push_s ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
    rd_ptr_d = pop_s  ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;

    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Credit is evaluated on next-state values so the registered ready equals
  // the occupancy-plus-in-flight rule applied to the current registers.
  always_comb begin
    credit_sum_s = SUM_W'(count_d) + SUM_W'(s1_valid_d) + SUM_W'(s2_valid_d);
    req_ready_d  = (credit_sum_s < DEPTH_C);
    rsp_valid_d  = (count_d != CNT_W'(0));
  end

  // Pipeline and FIFO state registers
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      s1_valid_q   <= 1'b0;
      s1_op_q      <= 4'd0;
      s1_a_q       <= 32'd0;
      s1_b_q       <= 32'd0;
      s1_tag_q     <= '0;
      s2_valid_q   <= 1'b0;
      s2_tag_q     <= '0;
      s2_illegal_q <= 1'b0;
      for (int i = 0; i < RES_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      req_ready_q  <= 1'b1;
      rsp_valid_q  <= 1'b0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_op_q      <= s1_op_d;
      s1_a_q       <= s1_a_d;
      s1_b_q       <= s1_b_d;
      s1_tag_q     <= s1_tag_d;
      s2_valid_q   <= s2_valid_d;
      s2_tag_q     <= s2_tag_d;
      s2_illegal_q <= s2_illegal_d;
      for (int i = 0; i < RES_DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      req_ready_q  <= req_ready_d;
      rsp_valid_q  <= rsp_valid_d;
    end
  end

  assign head_s          = mem_q[rd_ptr_q];

  assign alu_in0         = s1_a_q;
  assign alu_in1         = s1_b_q;
  assign control_signal  = s1_op_q;

  assign bus.req_ready   = req_ready_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_result  = head_s.result;
  assign bus.rsp_zero    = head_s.zero;
  assign bus.rsp_illegal = head_s.illegal;
  assign bus.rsp_tag     = head_s.tag;

endmodule

// File: tb/tb_alu_req_sequencer.sv
// Directed scoreboard bench for alu_req_sequencer with a behavioural
// registered ALU attached to its operand/control ports.
module tb_alu_req_sequencer;

  localparam int TAG_W = 4;
  localparam int DEPTH = 4;

  logic        clk;
  logic        clear;
  logic [31:0] alu_in0;
  logic [31:0] alu_in1;
  logic [3:0]  control_signal;
  logic [31:0] alu_out;
  logic        zero_flag;

  alu_req_sequencer_if #(.TAG_W(TAG_W)) bus ();

  alu_req_sequencer #(.TAG_W(TAG_W), .RES_DEPTH(DEPTH)) dut (
    .clk            (clk),
    .clear          (clear),
    .bus            (bus),
    .alu_in0        (alu_in0),
    .alu_in1        (alu_in1),
    .control_signal (control_signal),
    .alu_out        (alu_out),
    .zero_flag      (zero_flag)
  );

  typedef struct packed {
    logic [31:0] result;
    logic        zero;
    logic        illegal;
    logic [3:0]  tag;
  } exp_t;

  exp_t sb[$];
  int   pop_cyc[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // ALU encoding: 0 ADD,1 SUB,2 AND,3 OR,4 XOR,5 SLT,6 SLTU,7 SLL,8 SRL,9 SRA
  function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                        input logic [3:0] op);
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      4'd5:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd6:    return (a < b) ? 32'd1 : 32'd0;
      4'd7:    return a << b[4:0];
      4'd8:    return a >> b[4:0];
      4'd9:    return 32'($signed(a) >>> b[4:0]);
      default: return 32'd0;
    endcase
  endfunction

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      alu_out   <= 32'd0;
      zero_flag <= 1'b1;
    end else begin
      alu_out   <= alu_f(alu_in0, alu_in1, control_signal);
      zero_flag <= (alu_f(alu_in0, alu_in1, control_signal) == 32'd0);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: compare the head against the scoreboard whenever it is popped
  always @(negedge clk) begin
    if (!clear && bus.rsp_valid && bus.rsp_ready) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_rsp: got tag %0d result 0x%08h, expected no response",
                 bus.rsp_tag, bus.rsp_result);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("rsp_result",  bus.rsp_result,        e.result);
        check("rsp_zero",    32'(bus.rsp_zero),     32'(e.zero));
        check("rsp_illegal", 32'(bus.rsp_illegal),  32'(e.illegal));
        check("rsp_tag",     32'(bus.rsp_tag),      32'(e.tag));
        pop_cyc.push_back(cyc);
      end
    end
  end

  task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [3:0] tag, input logic [31:0] exp_res, input logic exp_ill);
    int waited;
    waited = 0;
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_a     = a;
    bus.req_b     = b;
    bus.req_tag   = tag;
    @(negedge clk);
    while (!bus.req_ready && waited < 200) begin
      waited++;
      @(negedge clk);
    end
    if (!bus.req_ready) begin
      tests++;
      fails++;
      $display("FAIL accept_timeout: req_ready got 0, expected 1 within 200 cycles");
      bus.req_valid = 1'b0;
    end else begin
      @(posedge clk);
      sb.push_back('{exp_res, (exp_res == 32'd0), exp_ill, tag});
      #1;
      bus.req_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    int   base;
    int   n_acc;
    logic rdy;
    logic [31:0] head_res;
    logic [3:0]  head_tag;

    clear         = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_op    = 4'd0;
    bus.req_a     = 32'd0;
    bus.req_b     = 32'd0;
    bus.req_tag   = 4'd0;
    bus.rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    clear = 1'b0;

    // Reset state
    check("rst_req_ready",   32'(bus.req_ready),   32'd1);
    check("rst_rsp_valid",   32'(bus.rsp_valid),   32'd0);
    check("rst_rsp_result",  bus.rsp_result,       32'd0);
    check("rst_rsp_zero",    32'(bus.rsp_zero),    32'd0);
    check("rst_rsp_illegal", 32'(bus.rsp_illegal), 32'd0);
    check("rst_rsp_tag",     32'(bus.rsp_tag),     32'd0);
    check("rst_alu_in0",     alu_in0,              32'd0);
    check("rst_alu_in1",     alu_in1,              32'd0);
    check("rst_control",     32'(control_signal),  32'd0);

    // ADD latency: accept at E0, response visible after E2
    @(posedge clk);
    #1;
    send(4'd0, 32'd5, 32'd7, 4'd3, 32'h0000000C, 1'b0);
    check("lat_after_e0", 32'(bus.rsp_valid), 32'd0);
    @(posedge clk); #1;
    check("lat_after_e1", 32'(bus.rsp_valid), 32'd0);
    @(posedge clk); #1;
    check("lat_after_e2", 32'(bus.rsp_valid), 32'd1);
    drain();

    // Back-to-back XOR, SLT, ASR: one response per cycle, in order
    base = pop_cyc.size();
    send(4'd4, 32'hFFFF0000, 32'h0000FFFF, 4'd1, 32'hFFFFFFFF, 1'b0);
    send(4'd5, 32'hFFFFFFFF, 32'h00000001, 4'd2, 32'h00000001, 1'b0);
    send(4'd9, 32'h80000000, 32'h00000004, 4'd3, 32'hF8000000, 1'b0);
    drain();
    check("b2b_count", 32'(pop_cyc.size() - base), 32'd3);
    if (pop_cyc.size() >= base + 3) begin
      check("b2b_gap1", 32'(pop_cyc[base+1] - pop_cyc[base]),   32'd1);
      check("b2b_gap2", 32'(pop_cyc[base+2] - pop_cyc[base+1]), 32'd1);
    end

    // Illegal op, zero AND, and a few more encodings
    send(4'd12, 32'd9, 32'd9, 4'd7, 32'd0, 1'b1);
    send(4'd2, 32'hF0F0F0F0, 32'h0F0F0F0F, 4'd0, 32'd0, 1'b0);
    send(4'd1, 32'd3, 32'd5, 4'd4, 32'hFFFFFFFE, 1'b0);
    send(4'd7, 32'd1, 32'd31, 4'd5, 32'h80000000, 1'b0);
    send(4'd8, 32'h80000000, 32'd4, 4'd6, 32'h08000000, 1'b0);
    send(4'd6, 32'hFFFFFFFF, 32'd1, 4'd9, 32'd0, 1'b0);
    drain();

    // Back-pressure: consumer stalled, requester always valid
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    n_acc         = 0;
    bus.req_valid = 1'b1;
    bus.req_op    = 4'd0;
    bus.req_b     = 32'd100;
    bus.req_a     = 32'd0;
    bus.req_tag   = 4'd8;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      rdy = bus.req_ready;
      @(posedge clk);
      if (rdy) begin
        sb.push_back('{32'(100 + n_acc), 1'b0, 1'b0, 4'(8 + n_acc)});
        n_acc++;
        check("bp_outstanding_ok", 32'(sb.size() > DEPTH), 32'd0);
      end
      #1;
      bus.req_a   = 32'(n_acc);
      bus.req_tag = 4'(8 + n_acc);
    end
    bus.req_valid = 1'b0;
    check("bp_accepts",   32'(n_acc),          32'd4);
    check("bp_ready_low", 32'(bus.req_ready),  32'd0);
    check("bp_rsp_valid", 32'(bus.rsp_valid),  32'd1);
    check("bp_head_tag",  32'(bus.rsp_tag),    32'd8);
    head_res = bus.rsp_result;
    head_tag = bus.rsp_tag;
    repeat (3) @(posedge clk);
    #1;
    check("bp_head_stable_res", bus.rsp_result,    head_res);
    check("bp_head_stable_tag", 32'(bus.rsp_tag),  32'(head_tag));
    check("bp_head_result",     bus.rsp_result,    32'd100);
    bus.rsp_ready = 1'b1;
    check("bp_ready_at_pop",    32'(bus.req_ready), 32'd0);
    @(posedge clk); #1;
    check("bp_ready_after_pop", 32'(bus.req_ready), 32'd1);
    drain();

    // Clear between E0 and E1 of the third request discards everything
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    send(4'd0, 32'd10, 32'd1, 4'd1, 32'd11, 1'b0);
    send(4'd0, 32'd10, 32'd2, 4'd2, 32'd12, 1'b0);
    send(4'd0, 32'd10, 32'd3, 4'd3, 32'd13, 1'b0);
    #1;
    clear = 1'b1;
    #1;
    check("clr_req_ready",  32'(bus.req_ready),  32'd1);
    check("clr_rsp_valid",  32'(bus.rsp_valid),  32'd0);
    check("clr_rsp_result", bus.rsp_result,      32'd0);
    check("clr_rsp_tag",    32'(bus.rsp_tag),    32'd0);
    check("clr_alu_in0",    alu_in0,             32'd0);
    check("clr_control",    32'(control_signal), 32'd0);
    sb.delete();
    @(negedge clk);
    clear = 1'b0;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("clr_no_rsp", 32'(bus.rsp_valid), 32'd0);
    send(4'd0, 32'd1, 32'd1, 4'd5, 32'd2, 1'b0);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation got no finish, expected completion before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
